// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256 round controller and its constant ROM:
//   - SHA256_ROUNDS : rounds per 512-bit block
//   - state_t       : controller state encoding (2 bits)
//   - SHA256_K      : round constants K[0..63]
//   - sha256_k()    : constant lookup by 6-bit round index
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_FINAL = 2'd3
  } state_t;

  // Index 0 is the leftmost entry of the concatenation.
  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sha256_k(input logic [5:0] idx);
    return SHA256_K[idx];
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom
//   Registered 64x32 SHA-256 round-constant ROM.
//   Ports:
//     clk  in   1  - core clock, rising edge
//     rst  in   1  - asynchronous active-high reset (output returns to K[0])
//     addr in   6  - round index to look up
//     k    out 32  - K[addr], one clock after addr
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) k <= sha256_k(6'd0);
    else     k <= sha256_k(addr);
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
//   Round sequencer for the SHA-256 core. Takes one 512-bit block per
//   valid/ready handshake, drives the message-schedule load/busy strobes and
//   produces round index, round constant, working-variable init and hash
//   update strobes for the compression datapath.
//
//   Build option: define SHA256_CTRL_KROM_EN to instantiate the internal
//   constant ROM on k_o; otherwise k_o is tied to 0 and the datapath keeps
//   its own K table indexed by round_o.
//
//   Ports:
//     clk          in   1  - core clock, rising edge
//     rst_i        in   1  - asynchronous active-high reset
//     blk_valid_i  in   1  - block presented on the schedule unit's data_i
//     blk_init_i   in   1  - block is the first of a new message
//     blk_ready_o  out  1  - controller accepts a block (IDLE and no abort)
//     abort_i      in   1  - cancel current block, return to IDLE
//     load_o       out  1  - schedule load strobe (LOAD cycle)
//     busy_o       out  1  - schedule busy (ROUND cycles)
//     round_o      out  6  - round index 0..63
//     k_o          out 32  - K[round_o] (ROM build) or 0
//     init_o       out  1  - working vars start from IV (LOAD cycle)
//     first_o      out  1  - load working vars from H (LOAD cycle)
//     upd_o        out  1  - add working vars into H (FINAL cycle)
//     done_o       out  1  - block complete pulse (FINAL cycle)
//     blk_cnt_o    out 16  - blocks completed in the current message
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a block; blk_ready_o = ~abort_i
//   ST_LOAD  | one cycle: schedule loads data_i, working vars load from H/IV
//   ST_ROUND | ROUNDS cycles: round_o counts 0..ROUNDS-1
//   ST_FINAL | one cycle: hash update, done pulse, block count increments
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        blk_valid_i,
  input  logic        blk_init_i,
  output logic        blk_ready_o,
  input  logic        abort_i,
  output logic        load_o,
  output logic        busy_o,
  output logic [5:0]  round_o,
  output logic [31:0] k_o,
  output logic        init_o,
  output logic        first_o,
  output logic        upd_o,
  output logic        done_o,
  output logic [15:0] blk_cnt_o
);

  state_t      state, state_nxt;
  logic        accept;
  logic        last_round;
  logic        load_nxt, busy_nxt, init_nxt, first_nxt, upd_nxt, done_nxt;
  logic [5:0]  round_nxt;
  logic [15:0] cnt_nxt;

  assign blk_ready_o = (state == ST_IDLE) & ~abort_i;
  assign accept      = blk_ready_o & blk_valid_i;
  assign last_round  = (round_o == 6'(ROUNDS - 1));

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_ROUND;
      ST_ROUND: if (last_round) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_i) state_nxt = ST_IDLE;
  end

  // Registered outputs are decoded from the next state so that each strobe
  // lines up with the cycle in which the FSM actually sits in that state.
  // init_nxt samples blk_init_i only on the accepting IDLE cycle, which is
  // the one place LOAD can be entered from.
  always_comb begin
    load_nxt  = (state_nxt == ST_LOAD);
    first_nxt = (state_nxt == ST_LOAD);
    init_nxt  = (state_nxt == ST_LOAD) & blk_init_i;
    busy_nxt  = (state_nxt == ST_ROUND);
    upd_nxt   = (state_nxt == ST_FINAL);
    done_nxt  = (state_nxt == ST_FINAL);
    round_nxt = 6'd0;
    if ((state == ST_ROUND) && (state_nxt == ST_ROUND)) round_nxt = round_o + 6'd1;
    cnt_nxt = blk_cnt_o;
    if ((state_nxt == ST_LOAD) && blk_init_i) cnt_nxt = 16'd0;
    if (state_nxt == ST_FINAL) cnt_nxt = blk_cnt_o + 16'd1;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      load_o    <= 1'b0;
      busy_o    <= 1'b0;
      init_o    <= 1'b0;
      first_o   <= 1'b0;
      upd_o     <= 1'b0;
      done_o    <= 1'b0;
      round_o   <= 6'd0;
      blk_cnt_o <= 16'd0;
    end else begin
      load_o    <= load_nxt;
      busy_o    <= busy_nxt;
      init_o    <= init_nxt;
      first_o   <= first_nxt;
      upd_o     <= upd_nxt;
      done_o    <= done_nxt;
      round_o   <= round_nxt;
      blk_cnt_o <= cnt_nxt;
    end
  end

`ifdef SHA256_CTRL_KROM_EN
  // Addressed with the next round value so k_o changes on the same edge as
  // round_o and always equals K[round_o].
  sha256_k_rom u_k_rom (
    .clk  (clk),
    .rst  (rst_i),
    .addr (round_nxt),
    .k    (k_o)
  );
`else
  assign k_o = 32'd0;
`endif

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Round sequencer for the SHA-256 core. Accepts one 512-bit message block at a time over a valid/ready handshake and drives the message-schedule unit (`load`/`busy`). Produces the round index and round constant for the compression datapath, and signals the working-variable init and final hash-update cycles. Sits between the bus-facing block buffer and the `sha256_W` / compression datapath pair.

## Interface
Parameters:
- `ROUNDS`, 64 — rounds per block; fixed at 64 for SHA-256, kept as a parameter for the bench only.

Ports:
- `clk`  in  1  — core clock, rising edge.
- `rst_i`  in  1  — reset; asynchronous, active-high.
- `blk_valid_i`  in  1  — a 512-bit block is presented to the schedule unit's `data_i`.
- `blk_init_i`  in  1  — qualifies `blk_valid_i`: this block is the first of a new message (hash starts from IV).
- `blk_ready_o`  out  1  — controller can accept a block.
- `abort_i`  in  1  — cancel the current block, return to IDLE.
- `load_o`  out  1  — to schedule `load_i`.
- `busy_o`  out  1  — to schedule `busy_i`.
- `round_o`  out  6  — current round index 0..63.
- `k_o`  out  32  — round constant K[`round_o`].
- `init_o`  out  1  — working vars take IV instead of running hash (valid during LOAD).
- `first_o`  out  1  — load working vars a..h from H (LOAD cycle).
- `upd_o`  out  1  — add working vars into H (FINAL cycle).
- `done_o`  out  1  — one-cycle pulse, block complete.
- `blk_cnt_o`  out  16  — blocks completed in the current message.

## Operation
- States: IDLE, LOAD, ROUND, FINAL.
- IDLE: `blk_ready_o = ~abort_i`. On `blk_valid_i & blk_ready_o`, latch `blk_init_i` and go to LOAD.
- LOAD (1 cycle): `load_o=1`, `first_o=1`, `init_o` = latched init. Round counter cleared to 0. If init is set, `blk_cnt_o` clears to 0. Next state: ROUND.
- ROUND (64 cycles): `busy_o=1`. `round_o` counts 0..63. `W_o` from the schedule is W[`round_o`] in the same cycle. At `round_o==63`, go to FINAL.
- FINAL (1 cycle): `upd_o=1`, `done_o=1`, `blk_cnt_o` increments (wraps 0xFFFF→0). Next state: IDLE.
- `abort_i` in any state has priority:
  - Next state is IDLE.
  - No `upd_o`/`done_o`; `blk_cnt_o` unchanged.
  - A block offered in the same IDLE cycle is not accepted.
- `blk_valid_i` outside IDLE is ignored. The source must hold `data_i` stable only through the LOAD cycle.
- `round_o` holds 0 in IDLE/LOAD/FINAL. `k_o` follows `round_o`.

## Timing
- All outputs are registered except `blk_ready_o` (state decode AND `~abort_i`).
- Reset values:
  - state IDLE
  - `blk_ready_o=1` (with `abort_i` low)
  - `load_o`, `busy_o`, `first_o`, `init_o`, `upd_o`, `done_o` = 0
  - `round_o=0`, `blk_cnt_o=0`
  - `k_o` = K[0] with ROM, 0 without.
- Handshake in cycle T:
  - LOAD at T+1
  - ROUND at T+2..T+65
  - FINAL/`done_o` at T+66
  - `blk_ready_o` high again at T+67
- Minimum block-to-block spacing: 67 cycles.
- `rst_i` mid-operation: immediate return to reset values. No partial `upd_o`.

## Configuration
- `SHA256_CTRL_KROM_EN` defined:
  - The internal 64×32 constant ROM drives `k_o`, registered alongside `round_o`.
- Undefined:
  - No ROM; `k_o` is tied to 0.
  - The datapath indexes its own K table with `round_o`.
- All other behaviour is identical in both builds.

## Structure
- Shared package `sha256_pkg` holds:
  - the K[0..63] constant table
  - the state encoding (2 bits: IDLE=0, LOAD=1, ROUND=2, FINAL=3)
  - `SHA256_ROUNDS=64`
- Sub-module `sha256_k_rom`: 6-bit address in, 32-bit constant out, registered. Instantiated only under `SHA256_CTRL_KROM_EN`.

## Test plan
- Reset, then one block with `blk_init_i=1` offered at T:
  - `load_o` at T+1
  - `busy_o` T+2..T+65 with `round_o` 0..63
  - `upd_o`/`done_o` at T+66, `blk_cnt_o=1`
  - `k_o` = 0x428a2f98 at round 0 and 0xc67178f2 at round 63 (ROM build).
- Paired with `sha256_W` and the compression datapath, block "abc" padded:
  - digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two back-to-back blocks, second with `blk_init_i=0`:
  - `blk_ready_o` low from T+1 to T+66
  - second accepted at T+67
  - `init_o` low in its LOAD, `blk_cnt_o=2`.
- `abort_i` at `round_o==30`:
  - IDLE next cycle, `busy_o` drops
  - no `done_o`, `blk_cnt_o` unchanged.
- `abort_i` and `blk_valid_i` together in IDLE:
  - `blk_ready_o=0`, no LOAD.
- `rst_i` asserted asynchronously mid-ROUND:
  - all outputs reach reset values without a clock edge
  - `blk_cnt_o=0`.
